predistort_taps_loader: RTL and testbench

PREDISTORT_TAPS_LOADER -- requirements
Module: predistort_taps_loader

---
 rtl/predistort_pkg.sv | 16 +
 rtl/predistort_taps_loader_if.sv | 30 +++
 rtl/predistort_taps_ram.sv | 31 +++
 rtl/predistort_taps_loader.sv | 149 ++++++++++++++
 tb/tb_predistort_taps_loader.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/predistort_pkg.sv
// Shared definitions for the predistortion blocks.
//   TAPS_WIDTH / TAPS_DEPTH : default tap word width and log2 of taps per table
//   loader_state_t          : state encoding of the tap-table loader FSM
package predistort_pkg;

    localparam int TAPS_WIDTH = 16;
    localparam int TAPS_DEPTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } loader_state_t;

endpackage

// File: rtl/predistort_taps_loader_if.sv
// AXI-Stream tap sink bundle for the predistortion tap loader.
//   taps_tdata  : tap word
//   taps_tlast  : marks the final tap of a table
//   taps_tvalid : source has a beat
//   taps_tready : loader accepts the beat
// master = tap source, slave = loader.
interface predistort_taps_loader_if
    import predistort_pkg::*;
#(
    parameter int WIDTH = TAPS_WIDTH
);
    logic [WIDTH-1:0] taps_tdata;
    logic             taps_tlast;
    logic             taps_tvalid;
    logic             taps_tready;

    modport master (
        output taps_tdata,
        output taps_tlast,
        output taps_tvalid,
        input  taps_tready
    );

    modport slave (
        input  taps_tdata,
        input  taps_tlast,
        input  taps_tvalid,
        output taps_tready
    );
endinterface

// File: rtl/predistort_taps_ram.sv
// Both tap banks as one simple dual-port RAM of 2N entries, addressed
// {bank, index}. One write port, one registered read port, no reset so the
// array maps onto block RAM.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : {bank, index} write address
//   wr_data : tap word to store
//   rd_addr : {bank, index} read address
//   rd_data : word at rd_addr, one cycle later
module predistort_taps_ram
    import predistort_pkg::*;
#(
    parameter int WIDTH = TAPS_WIDTH,
    parameter int DEPTH = TAPS_DEPTH
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [DEPTH:0]   wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [DEPTH:0]   rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [0:(2**(DEPTH+1))-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/predistort_taps_loader.sv
// Double-buffered predistortion tap table loader. A table of N = 2^DEPTH taps
// streams into the shadow bank; once exactly N taps arrive the loader waits for
// swap_en (datapath between packets) and then flips the active bank.
//   clk, reset_n   : clock, synchronous active-low reset
//   clear          : synchronous abort of any load in progress
//   taps           : AXI-Stream tap sink (slave modport)
//   swap_en        : bank swap permitted this cycle
//   rd_addr        : lookup address into the active bank
//   rd_data        : active-bank word, one cycle after rd_addr
//   table_valid    : a table has been committed since reset
//   bank_sel       : active bank index
//   commit, err_short, err_long : one-cycle event pulses
module predistort_taps_loader
    import predistort_pkg::*;
#(
    parameter int WIDTH = TAPS_WIDTH,
    parameter int DEPTH = TAPS_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    predistort_taps_loader_if.slave   taps,
    input  logic                      swap_en,
    input  logic [DEPTH-1:0]          rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      table_valid,
    output logic                      bank_sel,
    output logic                      commit,
    output logic                      err_short,
    output logic                      err_long
);
    localparam logic [DEPTH-1:0] IDX_LAST = '1;

    loader_state_t    state_reg, state_next;
    logic [DEPTH-1:0] idx_reg, idx_next;
    logic             bank_sel_reg, bank_sel_next;
    logic             table_valid_reg, table_valid_next;
    logic             commit_reg, commit_next;
    logic             err_short_reg, err_short_next;
    logic             err_long_reg, err_long_next;
    logic             tready;
    logic             accept;
    logic             wr_req;
    logic             wr_en;

    assign tready = (state_reg != ST_WAIT_SWAP);
    assign accept = taps.taps_tvalid && tready;

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        bank_sel_next    = bank_sel_reg;
        table_valid_next = table_valid_reg;
        commit_next      = 1'b0;
        err_short_next   = 1'b0;
        err_long_next    = 1'b0;
        wr_req           = 1'b0;

        if (clear) begin
            // Abort wins over everything; the beat of this cycle is swallowed.
            state_next = ST_IDLE;
            idx_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        wr_req = 1'b1;
                        if (taps.taps_tlast) begin
                            idx_next = '0;
                            if (idx_reg == IDX_LAST) begin
                                state_next = ST_WAIT_SWAP;
                            end else begin
                                err_short_next = 1'b1;
                                state_next     = ST_IDLE;
                            end
                        end else if (idx_reg == IDX_LAST) begin
                            // Table full but packet continues: drop the tail.
                            idx_next   = '0;
                            state_next = ST_DRAIN;
                        end else begin
                            idx_next   = idx_reg + 1'b1;
                            state_next = ST_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && taps.taps_tlast) begin
                        err_long_next = 1'b1;
                        state_next    = ST_IDLE;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (swap_en) begin
                        bank_sel_next    = ~bank_sel_reg;
                        table_valid_next = 1'b1;
                        commit_next      = 1'b1;
                        state_next       = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= '0;
            bank_sel_reg    <= 1'b0;
            table_valid_reg <= 1'b0;
            commit_reg      <= 1'b0;
            err_short_reg   <= 1'b0;
            err_long_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            bank_sel_reg    <= bank_sel_next;
            table_valid_reg <= table_valid_next;
            commit_reg      <= commit_next;
            err_short_reg   <= err_short_next;
            err_long_reg    <= err_long_next;
        end
    end

    // A beat arriving while reset is held must not disturb either bank.
    assign wr_en = wr_req && reset_n;

    predistort_taps_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({~bank_sel_reg, idx_reg}),
        .wr_data (taps.taps_tdata),
        .rd_addr ({bank_sel_reg, rd_addr}),
        .rd_data (rd_data)
    );

    assign taps.taps_tready = tready;
    assign table_valid      = table_valid_reg;
    assign bank_sel         = bank_sel_reg;
    assign commit           = commit_reg;
    assign err_short        = err_short_reg;
    assign err_long         = err_long_reg;
endmodule

// File: tb/tb_predistort_taps_loader.sv
// Directed bench for predistort_taps_loader. A packet-level model (beat count
// per packet, pending-table flag, two bank arrays) predicts every output each
// cycle; literal checks pin the model at key points of each scenario.
module tb_predistort_taps_loader;
    import predistort_pkg::*;

    localparam int W = 16;
    localparam int D = 7;
    localparam int N = 128;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         swap_en = 1'b0;
    logic [D-1:0] rd_addr = '0;
    logic [W-1:0] rd_data;
    logic         table_valid, bank_sel, commit, err_short, err_long;
    bit           rd_hold = 1'b0;

    predistort_taps_loader_if #(.WIDTH(W)) taps ();

    predistort_taps_loader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .taps        (taps),
        .swap_en     (swap_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .table_valid (table_valid),
        .bank_sel    (bank_sel),
        .commit      (commit),
        .err_short   (err_short),
        .err_long    (err_long)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_commit = 0, n_short = 0, n_long = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_mem   [0:1][0:N-1];
    bit           m_known [0:1][0:N-1];
    int           m_cnt = 0;          // beats accepted in the current packet
    bit           m_pending = 0;      // a complete table waits for swap_en
    bit           m_sel = 0, m_valid = 0;
    bit           m_commit = 0, m_short = 0, m_long = 0;
    logic [W-1:0] m_rd;
    bit           m_rd_known = 0;
    bit           model_live = 0;

    always @(posedge clk) begin
        int a;
        bit acc;
        a          = int'(rd_addr);
        m_rd       = m_mem[m_sel][a];
        m_rd_known = m_known[m_sel][a] && m_valid;
        m_commit   = 0;
        m_short    = 0;
        m_long     = 0;
        acc        = (taps.taps_tvalid === 1'b1) && !m_pending;
        if (!reset_n) begin
            m_cnt = 0; m_pending = 0; m_sel = 0; m_valid = 0;
        end else if (clear) begin
            m_cnt = 0; m_pending = 0;
        end else if (m_pending) begin
            if (swap_en) begin
                m_sel = !m_sel; m_valid = 1; m_commit = 1; m_pending = 0;
            end
        end else if (acc) begin
            m_cnt++;
            if (m_cnt <= N) begin
                m_mem[!m_sel][m_cnt-1]   = taps.taps_tdata;
                m_known[!m_sel][m_cnt-1] = 1;
            end
            if (taps.taps_tlast) begin
                if (m_cnt == N)     m_pending = 1;
                else if (m_cnt < N) m_short = 1;
                else                m_long = 1;
                m_cnt = 0;
            end
        end
        model_live = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            chk("tready", taps.taps_tready, !m_pending);
            chk("bank_sel", bank_sel, m_sel);
            chk("table_valid", table_valid, m_valid);
            chk("commit", commit, m_commit);
            chk("err_short", err_short, m_short);
            chk("err_long", err_long, m_long);
            if (m_rd_known) chk("rd_data", rd_data, m_rd);
            if (commit === 1'b1)    n_commit++;
            if (err_short === 1'b1) n_short++;
            if (err_long === 1'b1)  n_long++;
        end
    end

    // Random lookups keep the read path exercised unless a test pins rd_addr.
    always @(negedge clk) begin
        if (!rd_hold) rd_addr = D'($urandom_range(0, N-1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [W-1:0] d, input bit last, input bit with_clear);
        bit got;
        got = 0;
        taps.taps_tdata  = d;
        taps.taps_tlast  = last;
        taps.taps_tvalid = 1'b1;
        clear            = with_clear;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            if (taps.taps_tready === 1'b1) got = 1;
            @(posedge clk);
            #1;
        end
        taps.taps_tvalid = 1'b0;
        taps.taps_tlast  = 1'b0;
        clear            = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake: beat %0h not accepted within 64 cycles", d);
        end
    endtask

    task automatic send_pkt(input int n, input logic [W-1:0] base, input int gap_every, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            beat(base + W'(i), last_on_final && (i == n-1), 1'b0);
            if (gap_every > 0 && (i % gap_every) == gap_every-1) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_swap();
        swap_en = 1'b1;
        @(posedge clk);
        #1;
        swap_en = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [D-1:0] addr, input logic [W-1:0] exp);
        rd_hold = 1;
        rd_addr = addr;
        @(posedge clk);
        @(negedge clk);
        chk(name, rd_data, exp);
        rd_hold = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        taps.taps_tdata  = '0;
        taps.taps_tlast  = 1'b0;
        taps.taps_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_tready", taps.taps_tready, 1);
        chk("rst_bank_sel", bank_sel, 0);
        chk("rst_table_valid", table_valid, 0);
        @(posedge clk);
        #1;

        // 1: exact 128-tap table, value k at index k
        send_pkt(N, 16'h0000, 7, 1);
        @(negedge clk);
        chk("t1_wait_tready", taps.taps_tready, 0);
        @(posedge clk);
        #1;
        do_swap();
        @(negedge clk);
        chk("t1_commit", commit, 1);
        chk("t1_bank_sel", bank_sel, 1);
        chk("t1_table_valid", table_valid, 1);
        @(posedge clk);
        #1;
        rd_check("t1_rd5", 7'd5, 16'd5);
        rd_check("t1_rd127", 7'd127, 16'd127);
        settle();
        chk("t1_commit_count", n_commit, 1);

        // 2: short table, then a normal table
        send_pkt(50, 16'h1000, 0, 1);
        settle();
        chk("t2_short_count", n_short, 1);
        chk("t2_bank_sel", bank_sel, 1);
        send_pkt(N, 16'h0100, 11, 1);
        do_swap();
        settle();
        chk("t2_commit_count", n_commit, 2);
        chk("t2_bank_sel_after", bank_sel, 0);
        rd_check("t2_rd3", 7'd3, 16'h0103);

        // 3: long table, beats 129/130 dropped
        send_pkt(130, 16'h0200, 0, 1);
        settle();
        chk("t3_long_count", n_long, 1);
        chk("t3_commit_count", n_commit, 2);
        chk("t3_bank_sel", bank_sel, 0);

        // 4: swap held off for 20 cycles
        send_pkt(N, 16'h0300, 0, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t4_hold_tready", taps.taps_tready, 0);
        end
        @(posedge clk);
        #1;
        do_swap();
        @(negedge clk);
        chk("t4_commit", commit, 1);
        chk("t4_bank_sel", bank_sel, 1);
        @(posedge clk);
        #1;
        rd_check("t4_rd9", 7'd9, 16'h0309);

        // 5b: clear together with swap_en in WAIT_SWAP
        send_pkt(N, 16'h0600, 0, 1);
        settle();
        clear   = 1'b1;
        swap_en = 1'b1;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        swap_en = 1'b0;
        @(negedge clk);
        chk("t5b_commit", commit, 0);
        chk("t5b_bank_sel", bank_sel, 1);
        chk("t5b_tready", taps.taps_tready, 1);
        settle();
        chk("t5b_commit_count", n_commit, 3);

        // 5a: clear at beat 60, then a fresh table must start at index 0
        send_pkt(59, 16'h0400, 5, 0);
        beat(16'h043B, 1'b0, 1'b1);
        @(negedge clk);
        chk("t5a_tready", taps.taps_tready, 1);
        chk("t5a_err_short", err_short, 0);
        @(posedge clk);
        #1;
        send_pkt(N, 16'h0500, 0, 1);
        do_swap();
        settle();
        chk("t5a_commit_count", n_commit, 4);
        chk("t5a_bank_sel", bank_sel, 0);
        rd_check("t5a_rd0", 7'd0, 16'h0500);

        // 6: reset pulse on beat 100 with bank 1 active
        send_pkt(N, 16'h0700, 0, 1);
        do_swap();
        settle();
        chk("t6_pre_bank_sel", bank_sel, 1);
        send_pkt(99, 16'h0900, 0, 0);
        taps.taps_tdata  = 16'h0963;
        taps.taps_tlast  = 1'b0;
        taps.taps_tvalid = 1'b1;
        reset_n          = 1'b0;
        @(posedge clk);
        #1;
        reset_n          = 1'b1;
        taps.taps_tvalid = 1'b0;
        @(negedge clk);
        chk("t6_bank_sel", bank_sel, 0);
        chk("t6_table_valid", table_valid, 0);
        chk("t6_tready", taps.taps_tready, 1);
        chk("t6_pulses", {commit, err_short, err_long}, 0);
        @(posedge clk);
        #1;
        send_pkt(N, 16'h0800, 13, 1);
        do_swap();
        settle();
        chk("t6_bank_sel_after", bank_sel, 1);
        rd_check("t6_rd100", 7'd100, 16'h0864);

        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
